// File: rtl/jt51_ch_wr.sv
// jt51_ch_wr: YM2151 channel-register write scheduler.
// A CPU data write to a channel register (0x20-0x3F) is held until the
// rotating 8-slot counter reaches the target channel. The data is then
// presented on dout with the matching update strobes for one cen period.
// Optional feature macro: JT51_CH_WR_QUEUE_EN
//   undefined : one pending write; busy while it is held
//   defined   : 4-entry in-order FIFO; busy when the FIFO is full
module jt51_ch_wr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       zero,
    input  logic       write,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [2:0] cur_ch,
    output logic [7:0] dout,
    output logic       up_rl_ch,
    output logic       up_fb_ch,
    output logic       up_con_ch,
    output logic       up_kc_ch,
    output logic       up_kf_ch,
    output logic       up_pms_ch,
    output logic       up_ams_ch,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] addr;
    logic [2:0] cnt;
    logic       addr_ok;
    logic       wr_req;
    logic       head_hit;
    logic       pop;
    logic [2:0] head_ch;
    logic [1:0] head_kind;
    logic [7:0] head_data;

    // Only 0x20-0x3F are per-channel registers handled here
    assign addr_ok  = (addr[7:5] == 3'b001);
    // Busy is the registered flag, so a write on a retiring edge is refused
    assign wr_req   = write & a0 & addr_ok & ~busy;
    assign head_hit = (state == PEND) && (cnt == head_ch);
    assign pop      = cen & head_hit;
    assign cur_ch   = cnt;
    assign dout     = head_data;

    // Slot counter: advances once per cen, zero resynchronises it to slot 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 3'd0;
        else if (cen)
            cnt <= zero ? 3'd0 : cnt + 3'd1;
    end

    // Address latch: address writes are always accepted, even while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr <= 8'h00;
        else if (write && !a0)
            addr <= din;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

`ifdef JT51_CH_WR_QUEUE_EN
    localparam int DEPTH = 4;

    // Entry layout: {tgt_ch[2:0], kind[1:0], data[7:0]}
    logic [12:0] fifo [DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [2:0]  count_nxt;

    assign {head_ch, head_kind, head_data} = fifo[rd_ptr];

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        count_nxt = count;
        if (wr_req && !pop)
            count_nxt = count + 3'd1;
        else if (!wr_req && pop)
            count_nxt = count - 3'd1;
    end

    // Next state: pending while any entry remains in the FIFO
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (wr_req) state_nxt = PEND;
            PEND: if (count_nxt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage, pointers and the registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= 13'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            busy   <= 1'b0;
        end else begin
            if (wr_req) begin
                fifo[wr_ptr] <= {addr[2:0], addr[4:3], din};
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count_nxt;
            busy  <= (count_nxt == 3'd4);
        end
    end
`else
    logic [2:0] tgt_ch;
    logic [1:0] kind;
    logic [7:0] data;

    assign head_ch   = tgt_ch;
    assign head_kind = kind;
    assign head_data = data;

    // Next state: one pending write, released at its slot
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (wr_req) state_nxt = PEND;
            PEND: if (pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single pending entry and its busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_ch <= 3'd0;
            kind   <= 2'd0;
            data   <= 8'h00;
            busy   <= 1'b0;
        end else begin
            if (wr_req) begin
                tgt_ch <= addr[2:0];
                kind   <= addr[4:3];
                data   <= din;
            end
            busy <= (state_nxt == PEND);
        end
    end
`endif

    // Strobe decode from registered state only: head entry at its slot
    always_comb begin
        up_rl_ch  = 1'b0;
        up_fb_ch  = 1'b0;
        up_con_ch = 1'b0;
        up_kc_ch  = 1'b0;
        up_kf_ch  = 1'b0;
        up_pms_ch = 1'b0;
        up_ams_ch = 1'b0;
        if (head_hit) begin
            case (head_kind)
                2'd0: begin
                    up_rl_ch  = 1'b1;
                    up_fb_ch  = 1'b1;
                    up_con_ch = 1'b1;
                end
                2'd1: up_kc_ch = 1'b1;
                2'd2: up_kf_ch = 1'b1;
                default: begin
                    up_pms_ch = 1'b1;
                    up_ams_ch = 1'b1;
                end
            endcase
        end
    end

endmodule
